// File: rtl/servo_ramp_scheduler.sv
// Frame-synchronous servo position scheduler: accepts per-channel target/step
// commands and slews each channel's position by at most one step per frame.
module servo_ramp_scheduler #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned FRAME_CYCLES = 719426,
  parameter logic [7:0]  DEF_STEP     = 8'd4,
  parameter logic [7:0]  CENTER       = 8'd128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_ch,
  input  logic [7:0]            cmd_target,
  input  logic [7:0]            cmd_step,
  input  logic                  cmd_en,
  output logic [8*NUM_CH-1:0]   pos_data,
  output logic [NUM_CH-1:0]     servo_en,
  output logic [NUM_CH-1:0]     busy,
  output logic                  all_settled,
  output logic                  frame_tick
);

  localparam int unsigned IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned FW = $clog2(FRAME_CYCLES);
  localparam logic [FW-1:0] LAST_CNT = FW'(FRAME_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CH - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t        state;
  logic [FW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [7:0]    pos  [NUM_CH];
  logic [7:0]    tgt  [NUM_CH];
  logic [7:0]    step [NUM_CH];

  logic          cmd_acc;
  logic          cmd_hit;
  logic [IW-1:0] cmd_idx;
  logic [7:0]    cur_pos, cur_tgt, new_pos;
  logic [8:0]    s9, up, dn, lo_lim;

  // frame_tick is registered one count early so it lines up with cnt == LAST_CNT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
      frame_tick <= (cnt == LAST_CNT - 1'b1);
    end
  end

  assign cmd_acc = cmd_valid && cmd_ready;
  assign cmd_hit = ({1'b0, cmd_ch} < 5'(NUM_CH));
  assign cmd_idx = cmd_ch[IW-1:0];

  // Slew at 9 bits so neither the step-up nor the step-down can wrap
  always_comb begin
    cur_pos = pos[idx];
    cur_tgt = tgt[idx];
    s9      = (step[idx] == 8'd0) ? 9'd255 : {1'b0, step[idx]};
    up      = {1'b0, cur_pos} + s9;
    dn      = {1'b0, cur_pos} - s9;
    lo_lim  = {1'b0, cur_tgt} + s9;
    new_pos = cur_pos;
    if (cur_pos < cur_tgt)
      new_pos = (up > {1'b0, cur_tgt}) ? cur_tgt : up[7:0];
    else if (cur_pos > cur_tgt)
      new_pos = ({1'b0, cur_pos} < lo_lim) ? cur_tgt : dn[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      cmd_ready <= 1'b0;
      servo_en  <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        pos[i]  <= CENTER;
        tgt[i]  <= CENTER;
        step[i] <= DEF_STEP;
      end
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_acc && cmd_hit) begin
            tgt[cmd_idx]      <= cmd_target;
            step[cmd_idx]     <= cmd_step;
            servo_en[cmd_idx] <= cmd_en;
          end
          if (frame_tick) begin
            state     <= SWEEP;
            idx       <= '0;
            cmd_ready <= 1'b0;
          end
        end
        SWEEP: begin
          pos[idx] <= new_pos;
          if (idx == LAST_IDX) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    pos_data = '0;
    busy     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      pos_data[8*i +: 8] = pos[i];
      busy[i]            = (pos[i] != tgt[i]);
    end
  end

  assign all_settled = ~|busy;

endmodule

// File: tb/tb_servo_ramp_scheduler.sv
// Directed bench for servo_ramp_scheduler with a short frame (20 clocks, 4 channels).
module tb_servo_ramp_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_ch;
  logic [7:0]  cmd_target;
  logic [7:0]  cmd_step;
  logic        cmd_en;
  logic [31:0] pos_data;
  logic [3:0]  servo_en;
  logic [3:0]  busy;
  logic        all_settled;
  logic        frame_tick;

  int tests = 0;
  int fails = 0;

  servo_ramp_scheduler #(
    .NUM_CH(4),
    .FRAME_CYCLES(20),
    .DEF_STEP(8'd4),
    .CENTER(8'd128)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch),
    .cmd_target(cmd_target),
    .cmd_step(cmd_step),
    .cmd_en(cmd_en),
    .pos_data(pos_data),
    .servo_en(servo_en),
    .busy(busy),
    .all_settled(all_settled),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ch;
    logic [7:0]  tgt;
    logic [7:0]  step;
    logic        en;
    logic [31:0] p0, p1, p2;
    logic [3:0]  b0, b1, b2;
    logic [3:0]  exp_en;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_tick();
    bit seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (frame_tick) begin
        seen = 1'b1;
        break;
      end
    end
    check("tick_timeout", 32'(seen), 32'd1);
  endtask

  task automatic send_cmd(input logic [3:0] ch, input logic [7:0] t,
                          input logic [7:0] s, input logic e);
    bit ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (cmd_ready && !frame_tick) begin
        ok = 1'b1;
        break;
      end
    end
    check("cmd_ready_timeout", 32'(ok), 32'd1);
    cmd_ch = ch; cmd_target = t; cmd_step = s; cmd_en = e;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic check_frame(input string name, input logic [31:0] p,
                             input logic [3:0] b, input logic [3:0] e);
    wait_tick();
    repeat (5) @(negedge clk);
    check({name, "_pos"}, pos_data, p);
    check({name, "_busy"}, 32'(busy), 32'(b));
    check({name, "_en"}, 32'(servo_en), 32'(e));
  endtask

  initial begin
    int n;
    int lows;

    vecs[0] = '{4'd1, 8'd140, 8'd4,  1'b1, 32'h80808480, 32'h80808880, 32'h80808C80,
                4'b0010, 4'b0010, 4'b0000, 4'b0010};
    vecs[1] = '{4'd2, 8'd0,   8'd50, 1'b1, 32'h804E8C80, 32'h801C8C80, 32'h80008C80,
                4'b0100, 4'b0100, 4'b0000, 4'b0110};
    vecs[2] = '{4'd3, 8'd100, 8'd10, 1'b0, 32'h76008C80, 32'h6C008C80, 32'h64008C80,
                4'b1000, 4'b1000, 4'b0000, 4'b0110};
    vecs[3] = '{4'd1, 8'd141, 8'd0,  1'b0, 32'h64008D80, 32'h64008D80, 32'h64008D80,
                4'b0000, 4'b0000, 4'b0000, 4'b0100};
    vecs[4] = '{4'd7, 8'd0,   8'd1,  1'b1, 32'h64008D80, 32'h64008D80, 32'h64008D80,
                4'b0000, 4'b0000, 4'b0000, 4'b0100};

    reset = 1'b1; cmd_valid = 1'b0; cmd_ch = '0; cmd_target = '0; cmd_step = '0; cmd_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pos", pos_data, 32'h80808080);
    check("rst_en", 32'(servo_en), 32'd0);
    check("rst_settled", 32'(all_settled), 32'd1);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_tick", 32'(frame_tick), 32'd0);

    reset = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n++;
      if (n == 1) check("ready_after_rst", 32'(cmd_ready), 32'd1);
      if (frame_tick) break;
    end
    check("first_tick_delay", 32'(n), 32'd19);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n++;
      if (n == 1) check("tick_width", 32'(frame_tick), 32'd0);
      if (frame_tick) break;
    end
    check("tick_period", 32'(n), 32'd20);

    for (int v = 0; v < 5; v++) begin
      send_cmd(vecs[v].ch, vecs[v].tgt, vecs[v].step, vecs[v].en);
      check_frame($sformatf("v%0d_f0", v), vecs[v].p0, vecs[v].b0, vecs[v].exp_en);
      check_frame($sformatf("v%0d_f1", v), vecs[v].p1, vecs[v].b1, vecs[v].exp_en);
      check_frame($sformatf("v%0d_f2", v), vecs[v].p2, vecs[v].b2, vecs[v].exp_en);
    end

    // Jump command presented in the frame_tick cycle
    wait_tick();
    cmd_ch = 4'd0; cmd_target = 8'd255; cmd_step = 8'd0; cmd_en = 1'b1;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("jump_ready_low", 32'(cmd_ready), 32'd0);
    check("jump_before", pos_data, 32'h64008D80);
    @(negedge clk);
    check("jump_ch0", pos_data, 32'h64008DFF);
    check("jump_en", 32'(servo_en), 32'b0101);

    // cmd_valid held through the sweep
    wait_tick();
    @(negedge clk);
    cmd_ch = 4'd2; cmd_target = 8'd200; cmd_step = 8'd0; cmd_en = 1'b0;
    cmd_valid = 1'b1;
    lows = 0;
    for (int k = 0; k < 10; k++) begin
      if (cmd_ready) break;
      lows++;
      @(negedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    check("stall_cycles", 32'(lows), 32'd4);
    check("stall_busy", 32'(busy), 32'b0100);
    check_frame("stall", 32'h64C88DFF, 4'b0000, 4'b0001);

    send_cmd(4'd7, 8'd0, 8'd0, 1'b1);
    check_frame("bad_ch", 32'h64C88DFF, 4'b0000, 4'b0001);
    check("bad_ch_settled", 32'(all_settled), 32'd1);

    // Reset in the second sweep cycle
    send_cmd(4'd1, 8'd0, 8'd10, 1'b1);
    check("pre_rst_busy", 32'(busy), 32'b0010);
    wait_tick();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_pos", pos_data, 32'h80808080);
    check("mid_rst_en", 32'(servo_en), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd0);
    check("mid_rst_settled", 32'(all_settled), 32'd1);
    check("mid_rst_tick", 32'(frame_tick), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n++;
      if (frame_tick) break;
    end
    check("mid_rst_tick_delay", 32'(n), 32'd19);
    repeat (5) @(negedge clk);
    check("mid_rst_after_sweep", pos_data, 32'h80808080);
    check("mid_rst_after_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
